// File: rtl/sync_fifo_cnt.sv
// Single-clock FIFO with an explicit occupancy counter, registered read port
// and one-cycle overflow/underflow error pulses.
module sync_fifo_cnt #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] data_in,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic [CW-1:0]    fifo_words,
    output logic             wr_err,
    output logic             rd_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (fifo_words == CW'(DEPTH));
    assign empty = (fifo_words == '0);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Storage is deliberately left out of reset; the pointers and count discard it.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_words <= '0;
            data_out   <= '0;
            wr_err     <= 1'b0;
            rd_err     <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_ok;
            rd_err <= rd_en && !rd_ok;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   fifo_words <= fifo_words + CW'(1);
                2'b01:   fifo_words <= fifo_words - CW'(1);
                default: fifo_words <= fifo_words;
            endcase
        end
    end

endmodule
